// File: rtl/mem_stage_if.sv
// mem_stage_if
//   Signal bundle between the MEM stage and its neighbours (EX, data SRAM,
//   WB and the ID forwarding path).
//
//   Flow control: there is no valid/ready pair on this bus. Each stage is
//   stopped by its bit of `stall` (1 = stop). Content presented on
//   ex_to_mem_bus is accepted on a rising clk edge only when stall[3]=0.
//   stall[3]=1 with stall[4]=0 makes the MEM stage take a bubble (all
//   zeros). stall[3]=stall[4]=1 makes it hold its current content.
//
//   Signals
//     stall           per-stage stall vector
//     ex_to_mem_bus   EX->MEM bus
//     data_sram_rdata data SRAM read data
//     mem_to_wb_bus   MEM->WB bus
//     mem_to_rf_bus   MEM->ID forwarding bus
//     mem_adel        load address misaligned
//     mem_badvaddr    faulting address
//     state_dbg       hold FSM state (1 = HELD), for observation only
//
//   Modports
//     master  environment side (drives EX bus, stall, SRAM data)
//     slave   mem_stage side
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 80,
    parameter int MEM_TO_WB_WD = 70,
    parameter int MEM_TO_RF_WD = 38,
    parameter int STALL_WD     = 6
) ();
    logic [STALL_WD-1:0]     stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;
    logic                    mem_adel;
    logic [31:0]             mem_badvaddr;
    logic                    state_dbg;

    modport master (
        output stall, ex_to_mem_bus, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_rf_bus, mem_adel, mem_badvaddr, state_dbg
    );

    modport slave (
        input  stall, ex_to_mem_bus, data_sram_rdata,
        output mem_to_wb_bus, mem_to_rf_bus, mem_adel, mem_badvaddr, state_dbg
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
//   MEM stage of the 5-stage MIPS core, between EX and WB.
//   - Registers the EX->MEM bus, with stall/bubble control.
//   - Aligns and sign/zero-extends load data from the data SRAM. The SRAM
//     output is only valid in the first cycle a load sits in MEM, so it is
//     captured into a hold register when the stage is stalled.
//   - Produces the MEM->WB bus and the MEM->ID forwarding bus.
//
//   Ports
//     clk   clock
//     rst   synchronous reset, active-high
//     mif   mem_stage_if.slave (stall, ex_to_mem_bus, data_sram_rdata in;
//           mem_to_wb_bus, mem_to_rf_bus, mem_adel, mem_badvaddr,
//           state_dbg out)
//
//   Configuration macro
//     MEM_ADDR_EXC_EN  when defined, misaligned half/word loads raise
//                      mem_adel, report mem_badvaddr and suppress rf_we.
//                      When undefined, mem_adel/mem_badvaddr stay 0.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 80,
    parameter int MEM_TO_WB_WD = 70,
    parameter int MEM_TO_RF_WD = 38,
    parameter int STALL_WD     = 6
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave mif
);
    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } hold_state_t;

    logic [STALL_WD-1:0]     stall;
    logic [EX_TO_MEM_WD-1:0] bus_r;
    logic                    bus_hold;
    logic                    bus_bubble;

    assign stall      = mif.stall;
    assign bus_hold   = stall[3] & stall[4];
    assign bus_bubble = stall[3] & ~stall[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_r <= '0;
        end else if (bus_bubble) begin
            bus_r <= '0;
        end else if (!stall[3]) begin
            bus_r <= mif.ex_to_mem_bus;
        end
    end

    logic [3:0]  sel_id;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  byte_en;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic        is_load;

    assign {sel_id, pc, ram_en, byte_en, sel_rf_res, rf_we, waddr, result} = bus_r;
    assign is_load = ram_en & sel_rf_res;

    // Hold FSM. Capture happens only when the bus register will keep the
    // load next cycle; a bubble or a new latch releases the hold.
    hold_state_t state;
    hold_state_t state_nxt;
    logic [31:0] hold_r;
    logic        capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hold_r <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                hold_r <= mif.data_sram_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (is_load && bus_hold) begin
                    capture   = 1'b1;
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (!bus_hold) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load alignment and extension.
    logic [31:0] load_src;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    always_comb begin
        load_src  = (state == HELD) ? hold_r : mif.data_sram_rdata;
        lane_byte = '0;
        case (result[1:0])
            2'd0:    lane_byte = load_src[7:0];
            2'd1:    lane_byte = load_src[15:8];
            2'd2:    lane_byte = load_src[23:16];
            default: lane_byte = load_src[31:24];
        endcase
        lane_half = result[1] ? load_src[31:16] : load_src[15:0];
        case (sel_id[2:0])
            3'b100:  load_data = sel_id[3] ? {24'b0, lane_byte}
                                           : {{24{lane_byte[7]}}, lane_byte};
            3'b010:  load_data = sel_id[3] ? {16'b0, lane_half}
                                           : {{16{lane_half[15]}}, lane_half};
            default: load_data = load_src;
        endcase
    end

    logic [31:0] wdata;
    logic        adel;
    logic [31:0] badvaddr;
    logic        rf_we_out;

    assign wdata = is_load ? load_data : result;

`ifdef MEM_ADDR_EXC_EN
    assign adel      = is_load & ((sel_id[1] & result[0]) | (sel_id[0] & (|result[1:0])));
    assign badvaddr  = adel ? result : 32'b0;
    assign rf_we_out = rf_we & ~adel;
`else
    assign adel      = 1'b0;
    assign badvaddr  = 32'b0;
    assign rf_we_out = rf_we;
`endif

    logic [MEM_TO_WB_WD-1:0] wb_bus;
    logic [MEM_TO_RF_WD-1:0] rf_bus;

    assign wb_bus = {pc, rf_we_out, waddr, wdata};
    assign rf_bus = {rf_we_out, waddr, wdata};

    assign mif.mem_to_wb_bus = wb_bus;
    assign mif.mem_to_rf_bus = rf_bus;
    assign mif.mem_adel      = adel;
    assign mif.mem_badvaddr  = badvaddr;
    assign mif.state_dbg     = (state == HELD);

    // byte_en and the stall bits of other stages are not used here.
    logic unused_bits;
    assign unused_bits = ^{byte_en, stall[5], stall[2:0]};
endmodule
